// File: rtl/draw_rect_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank strobes and RGB444 colour.
// Pure wiring, no latency.
// No backpressure: one pixel per clock, always accepted.
interface draw_rect_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );

  modport slave (
    input hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );
endinterface

// File: rtl/draw_rect.sv
// Overlays a RECT_W x RECT_H rectangle at a per-frame latched (x,y) onto the VGA stream.
// Latency: exactly 2 clk on every timing and colour output, no bubbles.
// No backpressure: one pixel in and one pixel out per clock.
// Macro DRAW_RECT_OUTLINE_EN: draw only a BORDER_W-thick outline instead of a solid fill.
module draw_rect #(
  parameter int          RECT_W     = 48,
  parameter int          RECT_H     = 64,
`ifdef DRAW_RECT_OUTLINE_EN
  parameter int          BORDER_W   = 2,
`endif
  parameter logic [11:0] RECT_COLOR = 12'hF_8_0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  draw_rect_if.slave  vga_i,
  draw_rect_if.master vga_o
);

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_t;

  logic        vblnk_q;
  logic [11:0] x_lat_q, x_lat_d;
  logic [11:0] y_lat_q, y_lat_d;
  pix_t        s1_q, s1_d;
  pix_t        s2_q, s2_d;
  logic        draw_q, draw_d;

  // Bounds are computed at 13 bits so a rectangle reaching past 4095 clips instead of wrapping.
  logic [12:0] h_ext, v_ext;
  logic [12:0] x_lo, x_hi, y_lo, y_hi;
  logic        hit;

  assign h_ext = {2'b00, vga_i.hcount};
  assign v_ext = {2'b00, vga_i.vcount};
  assign x_lo  = {1'b0, x_lat_q};
  assign y_lo  = {1'b0, y_lat_q};
  assign x_hi  = x_lo + 13'(RECT_W);
  assign y_hi  = y_lo + 13'(RECT_H);
  assign hit   = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);

`ifdef DRAW_RECT_OUTLINE_EN
  logic [12:0] x_in_lo, x_in_hi, y_in_lo, y_in_hi;
  assign x_in_lo = x_lo + 13'(BORDER_W);
  assign x_in_hi = x_hi - 13'(BORDER_W);
  assign y_in_lo = y_lo + 13'(BORDER_W);
  assign y_in_hi = y_hi - 13'(BORDER_W);
  assign draw_d  = hit && ((h_ext < x_in_lo) || (h_ext >= x_in_hi) ||
                           (v_ext < y_in_lo) || (v_ext >= y_in_hi));
`else
  assign draw_d  = hit;
`endif

  // Capture the position only on the rising edge of vblank so a frame never tears.
  always_comb begin
    x_lat_d = x_lat_q;
    y_lat_d = y_lat_q;
    if (vga_i.vblnk && !vblnk_q) begin
      x_lat_d = xpos_i;
      y_lat_d = ypos_i;
    end
  end

  // Stage 1 copies the input pixel; stage 2 composites colour, forcing black in blanking.
  always_comb begin
    s1_d.hcount = vga_i.hcount;
    s1_d.hsync  = vga_i.hsync;
    s1_d.hblnk  = vga_i.hblnk;
    s1_d.vcount = vga_i.vcount;
    s1_d.vsync  = vga_i.vsync;
    s1_d.vblnk  = vga_i.vblnk;
    s1_d.rgb    = vga_i.rgb;
    s2_d        = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) begin
      s2_d.rgb = 12'h000;
    end else if (draw_q) begin
      s2_d.rgb = RECT_COLOR;
    end
  end

  // Position latch and vblank edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      x_lat_q <= '0;
      y_lat_q <= '0;
    end else begin
      vblnk_q <= vga_i.vblnk;
      x_lat_q <= x_lat_d;
      y_lat_q <= y_lat_d;
    end
  end

  // Two-stage pixel pipeline; reset discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      draw_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      draw_q <= draw_d;
    end
  end

  assign vga_o.hcount = s2_q.hcount;
  assign vga_o.hsync  = s2_q.hsync;
  assign vga_o.hblnk  = s2_q.hblnk;
  assign vga_o.vcount = s2_q.vcount;
  assign vga_o.vsync  = s2_q.vsync;
  assign vga_o.vblnk  = s2_q.vblnk;
  assign vga_o.rgb    = s2_q.rgb;

endmodule
